// File: rtl/vend_pkg.sv
// Shared widths, core encodings, product codes and arbiter state type
// for the vending-panel arbiter.
package vend_pkg;

  localparam int COIN_W  = 7;
  localparam int PCODE_W = 3;
  localparam int STATE_W = 4;

  localparam logic [STATE_W-1:0] CORE_IDLE_STATE = 4'd0;

  typedef enum logic [PCODE_W-1:0] {
    PCODE_PEN      = 3'b000,
    PCODE_NOTEBOOK = 3'b001,
    PCODE_COKE     = 3'b010,
    PCODE_WATER    = 3'b100
  } pcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_START,
    ST_WAIT,
    ST_CANCEL,
    ST_DONE
  } arb_state_e;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vend_rr_picker.sv
// Combinational round-robin pick: first requester strictly after the pointer,
// wrapping to the lowest requester when none lies above it.
module vend_rr_picker #(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [N-1:0] w_above;
  logic [N-1:0] w_pool;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_above
      assign w_above[gi] = i_req[gi] & (gi > int'(i_ptr));
    end
  endgenerate

  // Lowest set bit of the pool is the winner.
  assign w_pool   = (|w_above) ? w_above : i_req;
  assign o_onehot = w_pool & (~w_pool + N'(1));
  assign o_any    = |i_req;

  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (o_onehot[i]) o_idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/vend_panel_arbiter.sv
// Shares one vending core between NUM_PANELS panels with round-robin sessions.
// Define VEND_ARB_STATS_EN to add saturating o_vend_count / o_cancel_count ports.
module vend_panel_arbiter
  import vend_pkg::*;
#(
  parameter int NUM_PANELS     = 2,
  parameter int START_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [NUM_PANELS-1:0]         i_req,
  input  logic [NUM_PANELS-1:0]         i_req_cancel,
  input  logic [PCODE_W*NUM_PANELS-1:0] i_req_product_code,
  input  logic [NUM_PANELS-1:0]         i_req_online_payment,
  input  logic [COIN_W*NUM_PANELS-1:0]  i_req_coin_value,
  output logic [NUM_PANELS-1:0]         o_grant,
  output logic [NUM_PANELS-1:0]         o_done,
  output logic                          o_dispensed,
  output logic                          o_timeout,
  output logic [COIN_W-1:0]             o_change,
  output logic                          o_busy,
`ifdef VEND_ARB_STATS_EN
  output logic [15:0]                   o_vend_count,
  output logic [15:0]                   o_cancel_count,
`endif
  output logic                          o_core_start,
  output logic                          o_core_cancel,
  output logic [PCODE_W-1:0]            o_core_product_code,
  output logic                          o_core_online_payment,
  output logic [COIN_W-1:0]             o_core_coin_value,
  input  logic [STATE_W-1:0]            i_core_state,
  input  logic                          i_core_dispense,
  input  logic [COIN_W-1:0]             i_core_change
);

  localparam int IDX_W = idx_width(NUM_PANELS);
  localparam int PH_W  = $clog2(START_CYCLES + 1);
  localparam int WT_W  = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e              r_state;
  logic [NUM_PANELS-1:0]   r_grant;
  logic [IDX_W-1:0]        r_gidx;
  logic [IDX_W-1:0]        r_ptr;
  logic [PCODE_W-1:0]      r_core_code;
  logic                    r_core_online;
  logic [COIN_W-1:0]       r_core_coins;
  logic                    r_core_start;
  logic                    r_core_cancel;
  logic                    r_busy;
  logic [NUM_PANELS-1:0]   r_done;
  logic                    r_dispensed;
  logic                    r_timeout;
  logic [COIN_W-1:0]       r_change;
  logic [PH_W-1:0]         r_phase_cnt;
  logic [WT_W-1:0]         r_wait_cnt;
  logic                    r_seen_active;
  logic                    r_cancelled;
  logic                    r_timed_out;

  logic [NUM_PANELS-1:0]   w_pick_onehot;
  logic [IDX_W-1:0]        w_pick_idx;
  logic                    w_pick_any;
  logic [PCODE_W-1:0]      w_sel_code;
  logic                    w_sel_online;
  logic [COIN_W-1:0]       w_sel_coins;
  logic                    w_cancel_granted;
  logic                    w_core_idle;
  logic                    w_phase_last;
  logic                    w_wait_last;
  logic                    w_in_wait;
  logic                    w_wait_dispense;
  logic                    w_wait_idle_end;
  logic                    w_wait_cancel;
  logic                    w_wait_timeout;
  logic                    w_start_cancel;
  logic                    w_enter_cancel;
  logic                    w_enter_done;

  vend_rr_picker #(
    .N     (NUM_PANELS),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req    (i_req),
    .i_ptr    (r_ptr),
    .o_onehot (w_pick_onehot),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

  // One-hot select of the winning panel's session fields.
  always_comb begin
    w_sel_code   = '0;
    w_sel_online = 1'b0;
    w_sel_coins  = '0;
    for (int p = 0; p < NUM_PANELS; p++) begin
      if (w_pick_onehot[p]) begin
        w_sel_code   = i_req_product_code[p*PCODE_W +: PCODE_W];
        w_sel_online = i_req_online_payment[p];
        w_sel_coins  = i_req_coin_value[p*COIN_W +: COIN_W];
      end
    end
  end

  assign w_cancel_granted = |(i_req_cancel & r_grant);
  assign w_core_idle      = (i_core_state == CORE_IDLE_STATE);
  assign w_phase_last     = (r_phase_cnt == PH_W'(START_CYCLES - 1));
  assign w_wait_last      = (r_wait_cnt == WT_W'(TIMEOUT_CYCLES - 1));
  assign w_in_wait        = (r_state == ST_WAIT);

  // WAIT priority: dispense, core back to idle, panel cancel, timeout.
  // A panel cancel is honoured once per session so a held level cannot loop.
  assign w_wait_dispense = w_in_wait & i_core_dispense;
  assign w_wait_idle_end = w_in_wait & ~i_core_dispense & r_seen_active & w_core_idle;
  assign w_wait_cancel   = w_in_wait & ~i_core_dispense & ~w_wait_idle_end &
                           w_cancel_granted & ~r_cancelled;
  assign w_wait_timeout  = w_in_wait & ~i_core_dispense & ~w_wait_idle_end &
                           ~w_wait_cancel & w_wait_last;
  assign w_start_cancel  = (r_state == ST_START) & w_cancel_granted & ~r_cancelled;

  assign w_enter_cancel = w_start_cancel | w_wait_cancel | (w_wait_timeout & ~r_timed_out);
  assign w_enter_done   = w_wait_dispense | w_wait_idle_end | (w_wait_timeout & r_timed_out);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_grant       <= '0;
      r_gidx        <= '0;
      r_ptr         <= IDX_W'(NUM_PANELS - 1);
      r_core_code   <= '0;
      r_core_online <= 1'b0;
      r_core_coins  <= '0;
      r_core_start  <= 1'b0;
      r_core_cancel <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= '0;
      r_dispensed   <= 1'b0;
      r_timeout     <= 1'b0;
      r_change      <= '0;
      r_phase_cnt   <= '0;
      r_wait_cnt    <= '0;
      r_seen_active <= 1'b0;
      r_cancelled   <= 1'b0;
      r_timed_out   <= 1'b0;
    end else begin
      r_done      <= '0;
      r_dispensed <= 1'b0;
      r_timeout   <= 1'b0;

      if ((r_state == ST_START || r_state == ST_WAIT || r_state == ST_CANCEL) && !w_core_idle)
        r_seen_active <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (w_pick_any) begin
            r_state       <= ST_GRANT;
            r_grant       <= w_pick_onehot;
            r_gidx        <= w_pick_idx;
            r_core_code   <= w_sel_code;
            r_core_online <= w_sel_online;
            r_core_coins  <= w_sel_coins;
            r_busy        <= 1'b1;
            r_seen_active <= 1'b0;
            r_cancelled   <= 1'b0;
            r_timed_out   <= 1'b0;
          end
        end

        ST_GRANT: begin
          r_state      <= ST_START;
          r_core_start <= 1'b1;
          r_phase_cnt  <= '0;
        end

        ST_START: begin
          if (w_enter_cancel) begin
            r_core_start  <= 1'b0;
            r_core_cancel <= 1'b1;
            r_phase_cnt   <= '0;
            r_cancelled   <= 1'b1;
            r_state       <= ST_CANCEL;
          end else if (w_phase_last) begin
            r_core_start <= 1'b0;
            r_wait_cnt   <= '0;
            r_state      <= ST_WAIT;
          end else begin
            r_phase_cnt <= r_phase_cnt + PH_W'(1);
          end
        end

        ST_WAIT: begin
          if (w_enter_done) begin
            r_state     <= ST_DONE;
            r_done      <= r_grant;
            r_dispensed <= w_wait_dispense;
            r_timeout   <= r_timed_out | w_wait_timeout;
            r_change    <= w_wait_dispense ? i_core_change : '0;
          end else if (w_enter_cancel) begin
            r_core_cancel <= 1'b1;
            r_phase_cnt   <= '0;
            r_cancelled   <= 1'b1;
            r_state       <= ST_CANCEL;
            if (w_wait_timeout) r_timed_out <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WT_W'(1);
          end
        end

        ST_CANCEL: begin
          if (w_phase_last) begin
            r_core_cancel <= 1'b0;
            r_wait_cnt    <= '0;
            r_state       <= ST_WAIT;
          end else begin
            r_phase_cnt <= r_phase_cnt + PH_W'(1);
          end
        end

        ST_DONE: begin
          r_state       <= ST_IDLE;
          r_grant       <= '0;
          r_busy        <= 1'b0;
          r_ptr         <= r_gidx;
          r_core_code   <= '0;
          r_core_online <= 1'b0;
          r_core_coins  <= '0;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef VEND_ARB_STATS_EN
  logic [15:0] r_vend_count;
  logic [15:0] r_cancel_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vend_count   <= '0;
      r_cancel_count <= '0;
    end else begin
      if (w_wait_dispense && (r_vend_count != 16'hFFFF))
        r_vend_count <= r_vend_count + 16'd1;
      if (w_enter_cancel && (r_cancel_count != 16'hFFFF))
        r_cancel_count <= r_cancel_count + 16'd1;
    end
  end

  assign o_vend_count   = r_vend_count;
  assign o_cancel_count = r_cancel_count;
`endif

  assign o_grant               = r_grant;
  assign o_done                = r_done;
  assign o_dispensed           = r_dispensed;
  assign o_timeout             = r_timeout;
  assign o_change              = r_change;
  assign o_busy                = r_busy;
  assign o_core_start          = r_core_start;
  assign o_core_cancel         = r_core_cancel;
  assign o_core_product_code   = r_core_code;
  assign o_core_online_payment = r_core_online;
  assign o_core_coin_value     = r_core_coins;

endmodule

// File: tb/tb_vend_panel_arbiter.sv
// Directed bench for vend_panel_arbiter: session results are checked by a
// scoreboard monitor on o_done; timing and latched fields are checked inline.
module tb_vend_panel_arbiter;
  import vend_pkg::*;

  localparam int NP    = 2;
  localparam int START = 2;
  localparam int TMO   = 12;

  typedef struct packed {
    logic [1:0] done;
    logic       disp;
    logic       tmo;
    logic [6:0] chg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, cancel, online;
  logic [5:0]  pcode;
  logic [13:0] coins;
  logic [3:0]  core_state;
  logic        core_dispense;
  logic [6:0]  core_change;

  logic [1:0]  o_grant, o_done;
  logic        o_dispensed, o_timeout, o_busy;
  logic [6:0]  o_change, o_core_coin_value;
  logic        o_core_start, o_core_cancel, o_core_online_payment;
  logic [2:0]  o_core_product_code;
`ifdef VEND_ARB_STATS_EN
  logic [15:0] vend_count, cancel_count;
`endif

  int   total = 0;
  int   bad = 0;
  int   cancel_hi = 0;
  int   n;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  vend_panel_arbiter #(
    .NUM_PANELS     (NP),
    .START_CYCLES   (START),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .i_clk                 (clk),
    .i_rst_n               (rst_n),
    .i_req                 (req),
    .i_req_cancel          (cancel),
    .i_req_product_code    (pcode),
    .i_req_online_payment  (online),
    .i_req_coin_value      (coins),
    .o_grant               (o_grant),
    .o_done                (o_done),
    .o_dispensed           (o_dispensed),
    .o_timeout             (o_timeout),
    .o_change              (o_change),
    .o_busy                (o_busy),
`ifdef VEND_ARB_STATS_EN
    .o_vend_count          (vend_count),
    .o_cancel_count        (cancel_count),
`endif
    .o_core_start          (o_core_start),
    .o_core_cancel         (o_core_cancel),
    .o_core_product_code   (o_core_product_code),
    .o_core_online_payment (o_core_online_payment),
    .o_core_coin_value     (o_core_coin_value),
    .i_core_state          (core_state),
    .i_core_dispense       (core_dispense),
    .i_core_change         (core_change)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  function automatic logic [31:0] all_outs();
    logic [31:0] v;
    v = '0;
    v[26:0] = {o_grant, o_done, o_dispensed, o_timeout, o_busy, o_core_start,
               o_core_cancel, o_core_online_payment, o_core_product_code,
               o_core_coin_value, o_change};
    return v;
  endfunction

  function automatic logic sel(input int w);
    case (w)
      0:       return o_core_start;
      1:       return o_core_cancel;
      2:       return |o_done;
      default: return o_busy;
    endcase
  endfunction

  // Advances negedges until the selected output reaches lvl; n = edges advanced.
  task automatic wait_level(input int w, input logic lvl, input string nm, output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (sel(w) !== lvl && cnt < 400);
    if (sel(w) !== lvl) begin
      total++;
      bad++;
      $display("FAIL %s: timed out, level %0b never reached", nm, lvl);
    end
  endtask

  task automatic set_panel(input int p, input logic [2:0] code, input logic onl, input logic [6:0] c);
    if (p == 0) begin
      pcode[2:0] = code; online[0] = onl; coins[6:0] = c;
    end else begin
      pcode[5:3] = code; online[1] = onl; coins[13:7] = c;
    end
  endtask

  task automatic push_exp(input logic [1:0] d, input logic ds, input logic t, input logic [6:0] c);
    exp_t e;
    e.done = d; e.disp = ds; e.tmo = t; e.chg = c;
    exp_q.push_back(e);
  endtask

  // Called at a negedge while the arbiter is in WAIT.
  task automatic core_serve(input logic [6:0] chg);
    core_state = 4'd1;
    @(negedge clk);
    core_dispense = 1'b1;
    core_change   = chg;
    @(negedge clk);
    core_dispense = 1'b0;
    core_change   = '0;
    core_state    = 4'd0;
  endtask

  task automatic open_session(input logic [1:0] r, input logic [1:0] g, input string nm);
    req = r;
    @(negedge clk);
    check({nm, "_grant"}, 32'(o_grant), 32'(g));
    req = '0;
  endtask

  always @(negedge clk) begin
    if (o_core_cancel) cancel_hi++;
  end

  // Scoreboard monitor: every session end must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (o_done != 2'b00 || o_dispensed || o_timeout)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL done_unexpected: got done=%b disp=%b tmo=%b, none expected",
                 o_done, o_dispensed, o_timeout);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_panel",      32'(o_done),      32'(mon_e.done));
        check("done_grant_held", 32'(o_grant),     32'(mon_e.done));
        check("done_dispensed",  32'(o_dispensed), 32'(mon_e.disp));
        check("done_timeout",    32'(o_timeout),   32'(mon_e.tmo));
        check("done_change",     32'(o_change),    32'(mon_e.chg));
      end
    end
  end

  initial begin
    rst_n = 1'b0; req = '0; cancel = '0; online = '0; pcode = '0; coins = '0;
    core_state = '0; core_dispense = 1'b0; core_change = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", all_outs(), 32'h0);

    // Panel 0 alone, online payment, dispense with no change.
    set_panel(0, PCODE_PEN, 1'b1, 7'd0);
    push_exp(2'b01, 1'b1, 1'b0, 7'd0);
    open_session(2'b01, 2'b01, "t1");
    check("t1_online", 32'(o_core_online_payment), 32'd1);
    check("t1_busy", 32'(o_busy), 32'd1);
    wait_level(0, 1'b1, "t1_start_rise", n);
    wait_level(0, 1'b0, "t1_start_fall", n);
    check("t1_start_width", 32'(n), 32'(START));
    core_serve(7'd0);
    wait_level(3, 1'b0, "t1_idle", n);

    // Panel 1 notebook with 60 coins; change returned by the core.
    set_panel(1, PCODE_NOTEBOOK, 1'b0, 7'd60);
    push_exp(2'b10, 1'b1, 1'b0, 7'd25);
    open_session(2'b10, 2'b10, "t3");
    check("t3_core_code", 32'(o_core_product_code), 32'(PCODE_NOTEBOOK));
    check("t3_core_coins", 32'(o_core_coin_value), 32'd60);
    wait_level(0, 1'b1, "t3_start_rise", n);
    wait_level(0, 1'b0, "t3_start_fall", n);
    core_serve(7'd25);
    wait_level(3, 1'b0, "t3_idle", n);
    check("t3_change_held", 32'(o_change), 32'd25);
    check("t3_core_code_idle", 32'(o_core_product_code), 32'd0);

    // Both panels request together twice: round-robin 01 then 10.
    set_panel(0, PCODE_WATER, 1'b0, 7'd40);
    push_exp(2'b01, 1'b1, 1'b0, 7'd3);
    push_exp(2'b10, 1'b1, 1'b0, 7'd4);
    open_session(2'b11, 2'b01, "t2a");
    wait_level(0, 1'b1, "t2a_start_rise", n);
    wait_level(0, 1'b0, "t2a_start_fall", n);
    core_serve(7'd3);
    wait_level(3, 1'b0, "t2a_idle", n);
    open_session(2'b11, 2'b10, "t2b");
    wait_level(0, 1'b1, "t2b_start_rise", n);
    wait_level(0, 1'b0, "t2b_start_fall", n);
    core_serve(7'd4);
    wait_level(3, 1'b0, "t2b_idle", n);

    // Panel 0 cancels two cycles after start; core returns to idle.
    set_panel(0, PCODE_COKE, 1'b0, 7'd50);
    push_exp(2'b01, 1'b0, 1'b0, 7'd0);
    open_session(2'b01, 2'b01, "t4");
    check("t4_core_code", 32'(o_core_product_code), 32'(PCODE_COKE));
    wait_level(0, 1'b1, "t4_start_rise", n);
    repeat (2) @(negedge clk);
    cancel_hi  = 0;
    cancel     = 2'b01;
    core_state = 4'd1;
    wait_level(1, 1'b1, "t4_cancel_rise", n);
    core_state = 4'd0;
    wait_level(3, 1'b0, "t4_idle", n);
    cancel = 2'b00;
    check("t4_cancel_width", 32'(cancel_hi), 32'(START));

    // Core never leaves idle: timeout, forced cancel, second timeout ends it.
    set_panel(1, PCODE_WATER, 1'b1, 7'd20);
    push_exp(2'b10, 1'b0, 1'b1, 7'd0);
    open_session(2'b10, 2'b10, "t5");
    wait_level(0, 1'b1, "t5_start_rise", n);
    wait_level(0, 1'b0, "t5_start_fall", n);
    wait_level(1, 1'b1, "t5_cancel_rise", n);
    check("t5_first_timeout", 32'(n), 32'(TMO));
    wait_level(1, 1'b0, "t5_cancel_fall", n);
    check("t5_cancel_width", 32'(n), 32'(START));
    wait_level(2, 1'b1, "t5_done", n);
    check("t5_second_timeout", 32'(n), 32'(TMO));
    wait_level(3, 1'b0, "t5_idle", n);

    // Dispense and cancel in the same cycle: dispense wins, no core cancel.
    set_panel(0, PCODE_PEN, 1'b1, 7'd10);
    push_exp(2'b01, 1'b1, 1'b0, 7'd5);
    open_session(2'b01, 2'b01, "t6");
    wait_level(0, 1'b1, "t6_start_rise", n);
    wait_level(0, 1'b0, "t6_start_fall", n);
    cancel_hi = 0;
    cancel = 2'b01; core_state = 4'd1; core_dispense = 1'b1; core_change = 7'd5;
    @(negedge clk);
    cancel = 2'b00; core_state = 4'd0; core_dispense = 1'b0; core_change = '0;
    wait_level(3, 1'b0, "t6_idle", n);
    check("t6_no_cancel", 32'(cancel_hi), 32'd0);

    // Reset while panel 0 waits: silent abort, pointer returns to panel 0 first.
    set_panel(0, PCODE_COKE, 1'b1, 7'd30);
    open_session(2'b01, 2'b01, "t7");
    wait_level(0, 1'b1, "t7_start_rise", n);
    wait_level(0, 1'b0, "t7_start_fall", n);
    core_state = 4'd1;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t7_async_reset", all_outs(), 32'h0);
    core_state = 4'd0;
    @(negedge clk);
    check("t7_held_reset", all_outs(), 32'h0);
    rst_n = 1'b1;
    set_panel(0, PCODE_PEN, 1'b0, 7'd15);
    set_panel(1, PCODE_NOTEBOOK, 1'b0, 7'd15);
    push_exp(2'b01, 1'b1, 1'b0, 7'd9);
    open_session(2'b11, 2'b01, "t7_post");
    wait_level(0, 1'b1, "t7_start_rise2", n);
    wait_level(0, 1'b0, "t7_start_fall2", n);
    core_serve(7'd9);
    wait_level(3, 1'b0, "t7_idle", n);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
